// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared CPU definitions used by the TLB maintenance engine, its bus
//   interface, the vppn match helper and the combinational lookup unit.
//   Holds the TLB entry layout, address/ASID types, the TLB management
//   opcode set, INVTLB op codes, page-size constants and the maintenance
//   FSM state encoding.
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam int TLB_ENTRY_NUM = 16;
  localparam int VALEN         = 32;
  localparam int PS_4KB        = 12;
  localparam int PS_4MB        = 21;

  // The vppn field covers va[VALEN-1:13]; a 4KB page pair spans 8KB.
  localparam int VPPN_LSB      = 13;
  localparam int VPPN_W        = VALEN - VPPN_LSB;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [9:0]       asid_t;
  typedef logic [VALEN-1:0] virt_t;

  // Physical half of an entry (one per even/odd page of the pair).
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_entry_phy_t;

  typedef struct packed {
    logic              e;
    asid_t             asid;
    logic              g;
    logic [5:0]        ps;
    logic [VPPN_W-1:0] vppn;
    tlb_entry_phy_t    p0;
    tlb_entry_phy_t    p1;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    TLB_SRCH = 3'd0,
    TLB_RD   = 3'd1,
    TLB_WR   = 3'd2,
    TLB_FILL = 3'd3,
    TLB_INV  = 3'd4
  } tlb_op_t;

  // INVTLB op field encodings; anything above INV_GA_VA is illegal.
  localparam logic [4:0] INV_ALL     = 5'd0;
  localparam logic [4:0] INV_ALL_1   = 5'd1;
  localparam logic [4:0] INV_GLB     = 5'd2;
  localparam logic [4:0] INV_NGLB    = 5'd3;
  localparam logic [4:0] INV_ASID    = 5'd4;
  localparam logic [4:0] INV_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA   = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRCH = 2'd1,
    ST_INV  = 2'd2,
    ST_RESP = 2'd3
  } tlb_state_t;

endpackage

// File: rtl/tlb_maint_if.sv
// ---------------------------------------------------------------------------
// tlb_maint_if
//   Request/response bus between the execute stage (master) and the TLB
//   maintenance engine (slave), plus the registered entry array that the
//   engine exports to the lookup unit.
//   Request : req_valid/req_ready handshake, req_op, req_index, req_entry,
//             req_asid, req_va, req_inv_op
//   Response: resp_valid pulse, resp_hit, resp_index, resp_entry,
//             resp_inv_bad
//   Array   : entrys (engine -> lookup)
// ---------------------------------------------------------------------------
interface tlb_maint_if #(
  parameter int N = cpu_defs::TLB_ENTRY_NUM
) ();
  import cpu_defs::*;

  localparam int IDX_W = $clog2(N);

  logic                 req_valid;
  logic                 req_ready;
  tlb_op_t              req_op;
  logic [IDX_W-1:0]     req_index;
  tlb_entry_t           req_entry;
  asid_t                req_asid;
  virt_t                req_va;
  logic [4:0]           req_inv_op;

  tlb_entry_t [N-1:0]   entrys;

  logic                 resp_valid;
  logic                 resp_hit;
  logic [IDX_W-1:0]     resp_index;
  tlb_entry_t           resp_entry;
  logic                 resp_inv_bad;

  modport master (
    output req_valid, req_op, req_index, req_entry, req_asid, req_va,
           req_inv_op,
    input  req_ready, entrys, resp_valid, resp_hit, resp_index, resp_entry,
           resp_inv_bad
  );

  modport slave (
    input  req_valid, req_op, req_index, req_entry, req_asid, req_va,
           req_inv_op,
    output req_ready, entrys, resp_valid, resp_hit, resp_index, resp_entry,
           resp_inv_bad
  );

endinterface

// File: rtl/tlb_vppn_match.sv
// ---------------------------------------------------------------------------
// tlb_vppn_match
//   Combinational virtual-page compare of one TLB entry against a VA.
//   The page size comes from ps[0] (4MB when set, 4KB otherwise) and the
//   compare covers va[VALEN-1:PS+1] against the same bits of {vppn,13'b0}.
//   Shared by the maintenance engine and the lookup unit so both use one
//   match rule.
//   Ports: i_entry (entry under test), i_va (virtual address),
//          o_match (page match, ignores e/g/asid)
// ---------------------------------------------------------------------------
module tlb_vppn_match
  import cpu_defs::*;
(
  input  tlb_entry_t i_entry,
  input  virt_t      i_va,
  output logic       o_match
);

  // Lowest vppn bit that takes part in the compare for each page size.
  localparam int LO_4KB = PS_4KB + 1 - VPPN_LSB;
  localparam int LO_4MB = PS_4MB + 1 - VPPN_LSB;

  logic w_match_4kb;
  logic w_match_4mb;
  logic w_unused;

  assign w_match_4kb = (i_va[VALEN-1:PS_4KB+1] == i_entry.vppn[VPPN_W-1:LO_4KB]);
  assign w_match_4mb = (i_va[VALEN-1:PS_4MB+1] == i_entry.vppn[VPPN_W-1:LO_4MB]);
  assign o_match     = i_entry.ps[0] ? w_match_4mb : w_match_4kb;

  // Page offset bits and non-vppn fields never affect the compare.
  assign w_unused = ^{i_va[PS_4KB:0], i_entry.e, i_entry.asid, i_entry.g,
                      i_entry.ps[5:1], i_entry.p0, i_entry.p1};

endmodule

// File: rtl/tlb_maint.sv
// ---------------------------------------------------------------------------
// tlb_maint
//   TLB maintenance engine. Owns the TLB entry array and executes TLBSRCH,
//   TLBRD, TLBWR, TLBFILL and INVTLB. Single-entry ops finish in one cycle;
//   search and invalidate walk the array one entry per cycle.
//   Ports:
//     clk   - clock, all state changes on the rising edge
//     rst_n - asynchronous active-low reset (clears the array)
//     bus   - tlb_maint_if.slave: request handshake, response fields and
//             the registered entry array exported to the lookup unit
// ---------------------------------------------------------------------------
module tlb_maint #(
  parameter int TLB_ENTRY_NUM = cpu_defs::TLB_ENTRY_NUM
) (
  input  logic        clk,
  input  logic        rst_n,
  tlb_maint_if.slave  bus
);
  import cpu_defs::*;

  localparam int               IDX_W    = $clog2(TLB_ENTRY_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

  tlb_state_t                     r_state;
  tlb_state_t                     w_next_state;
  logic [IDX_W-1:0]               r_k;
  logic                           r_walk_done;
  logic [15:0]                    r_lfsr;
  tlb_entry_t [TLB_ENTRY_NUM-1:0] r_entrys;

  asid_t                          r_req_asid;
  virt_t                          r_req_va;
  logic [4:0]                     r_inv_op;

  logic                           r_resp_hit;
  logic                           r_resp_inv_bad;
  logic [IDX_W-1:0]               r_resp_index;
  tlb_entry_t                     r_resp_entry;

  logic                           w_accept;
  logic                           w_req_ready;
  logic                           w_resp_valid;
  logic                           w_inv_bad;
  logic                           w_last;
  tlb_entry_t                     w_cur;
  logic                           w_vppn_match;
  logic                           w_asid_ok;
  logic                           w_srch_hit;
  logic                           w_inv_hit;

  // Entry under the walk pointer, and its page compare against the
  // sampled VA.
  assign w_cur = r_entrys[r_k];

  tlb_vppn_match u_vppn_match (
    .i_entry (w_cur),
    .i_va    (r_req_va),
    .o_match (w_vppn_match)
  );

  assign w_asid_ok  = w_cur.g || (w_cur.asid == r_req_asid);
  assign w_srch_hit = w_cur.e && w_asid_ok && w_vppn_match;
  assign w_last     = (r_k == LAST_IDX);
  assign w_inv_bad  = (bus.req_inv_op > INV_GA_VA);

  // Per-entry INVTLB clear condition for the op latched at acceptance.
  always_comb begin
    w_inv_hit = 1'b0;
    case (r_inv_op)
      INV_ALL, INV_ALL_1: w_inv_hit = 1'b1;
      INV_GLB:            w_inv_hit = w_cur.g;
      INV_NGLB:           w_inv_hit = !w_cur.g;
      INV_ASID:           w_inv_hit = !w_cur.g && (w_cur.asid == r_req_asid);
      INV_ASID_VA:        w_inv_hit = !w_cur.g && (w_cur.asid == r_req_asid)
                                      && w_vppn_match;
      INV_GA_VA:          w_inv_hit = w_asid_ok && w_vppn_match;
      default:            w_inv_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The INV walk keeps one extra drain cycle after the last entry
  // (r_walk_done) before responding.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          case (bus.req_op)
            TLB_SRCH: w_next_state = ST_SRCH;
            TLB_INV:  w_next_state = w_inv_bad ? ST_RESP : ST_INV;
            default:  w_next_state = ST_RESP;
          endcase
        end
      end
      ST_SRCH: begin
        if (w_srch_hit || w_last) begin
          w_next_state = ST_RESP;
        end
      end
      ST_INV: begin
        if (r_walk_done) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Free-running Fibonacci LFSR (taps 16,14,13,11) picking the FILL slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Array writes, walk pointer, sampled request fields and response
  // registers. resp_inv_bad is refreshed on every acceptance; hit/index
  // only change on a search and resp_entry only on a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entrys       <= '0;
      r_k            <= '0;
      r_walk_done    <= 1'b0;
      r_req_asid     <= '0;
      r_req_va       <= '0;
      r_inv_op       <= '0;
      r_resp_hit     <= 1'b0;
      r_resp_inv_bad <= 1'b0;
      r_resp_index   <= '0;
      r_resp_entry   <= '0;
    end else begin
      if (w_accept) begin
        r_req_asid     <= bus.req_asid;
        r_req_va       <= bus.req_va;
        r_inv_op       <= bus.req_inv_op;
        r_k            <= '0;
        r_walk_done    <= 1'b0;
        r_resp_inv_bad <= (bus.req_op == TLB_INV) && w_inv_bad;
        case (bus.req_op)
          TLB_RD:   r_resp_entry <= r_entrys[bus.req_index];
          TLB_WR:   r_entrys[bus.req_index] <= bus.req_entry;
          TLB_FILL: r_entrys[r_lfsr[IDX_W-1:0]] <= bus.req_entry;
          default:  ;
        endcase
      end

      if (r_state == ST_SRCH) begin
        r_k <= r_k + 1'b1;
        if (w_srch_hit) begin
          r_resp_hit   <= 1'b1;
          r_resp_index <= r_k;
        end else if (w_last) begin
          r_resp_hit <= 1'b0;
        end
      end

      if ((r_state == ST_INV) && !r_walk_done) begin
        r_k <= r_k + 1'b1;
        if (w_inv_hit) begin
          r_entrys[r_k].e <= 1'b0;
        end
        if (w_last) begin
          r_walk_done <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.resp_valid   = w_resp_valid;
  assign bus.resp_hit     = r_resp_hit;
  assign bus.resp_index   = r_resp_index;
  assign bus.resp_entry   = r_resp_entry;
  assign bus.resp_inv_bad = r_resp_inv_bad;
  assign bus.entrys       = r_entrys;

endmodule

// File: tb/tb_tlb_maint.sv
// ---------------------------------------------------------------------------
// tb_tlb_maint
//   Self-checking bench for tlb_maint. A behavioural model (array of
//   entries, whole-array search/invalidate loops, LFSR sequence) predicts
//   every response, its latency and the exported array.
// ---------------------------------------------------------------------------
module tb_tlb_maint;
  import cpu_defs::*;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tlb_maint_if #(.N(N)) bus ();

  tlb_maint #(.TLB_ENTRY_NUM(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  tlb_entry_t mEnt [N];
  logic [15:0] mLfsr;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference LFSR: value held during the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mLfsr <= 16'hACE1;
    else        mLfsr <= lfsrNext(mLfsr);
  end

  function automatic bit pageMatch(input tlb_entry_t en, input virt_t va);
    int          s;
    logic [31:0] base;
    s    = en.ps[0] ? 21 : 12;
    base = {en.vppn, 13'b0};
    return (va >> (s + 1)) == (base >> (s + 1));
  endfunction

  function automatic bit invCond(input tlb_entry_t en, input int op,
                                 input asid_t asid, input virt_t va);
    bit same;
    same = (en.asid == asid);
    case (op)
      0, 1:    return 1'b1;
      2:       return en.g;
      3:       return !en.g;
      4:       return !en.g && same;
      5:       return !en.g && same && pageMatch(en, va);
      6:       return (en.g || same) && pageMatch(en, va);
      default: return 1'b0;
    endcase
  endfunction

  function automatic tlb_entry_t randEntry();
    tlb_entry_t en;
    en      = '0;
    en.e    = ($urandom_range(3) != 0);
    en.g    = ($urandom_range(3) == 0);
    en.asid = asid_t'(5 + $urandom_range(2));
    en.ps   = ($urandom_range(1) != 0) ? 6'd21 : 6'd12;
    case ($urandom_range(3))
      0:       en.vppn = 19'h12345;
      1:       en.vppn = 19'h1FE00;
      2:       en.vppn = 19'h1FE7F;
      default: en.vppn = 19'($urandom);
    endcase
    en.p0 = tlb_entry_phy_t'(26'($urandom));
    en.p1 = tlb_entry_phy_t'(26'($urandom));
    return en;
  endfunction

  function automatic virt_t randVa();
    logic [18:0] vp;
    virt_t       va;
    case ($urandom_range(3))
      0:       vp = 19'h12345;
      1:       vp = 19'h1FE00;
      2:       vp = 19'h1FE7F;
      default: vp = 19'($urandom);
    endcase
    va = {vp, 13'($urandom)};
    if ($urandom_range(2) == 0) va[21:13] = 9'($urandom);
    return va;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkArray(input string tag);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), bus.entrys[i], mEnt[i]);
    end
  endtask

  // Issue one request at the first ready cycle, predict its outcome from
  // the model, then check the response, its latency and the array.
  task automatic applyStimulus(input tlb_op_t op, input logic [IDX_W-1:0] idx,
                               input tlb_entry_t en, input asid_t asid,
                               input virt_t va, input logic [4:0] invOp);
    int         waitCycles;
    int         lat;
    int         expLat;
    bit         expHit;
    int         expIdx;
    bit         expBad;
    tlb_entry_t expEntry;

    waitCycles = 0;
    while (bus.req_ready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("req_ready_idle", bus.req_ready, 1'b1);

    expLat   = 1;
    expHit   = 1'b0;
    expIdx   = 0;
    expBad   = 1'b0;
    expEntry = '0;
    case (op)
      TLB_RD:   expEntry = mEnt[idx];
      TLB_WR:   mEnt[idx] = en;
      TLB_FILL: mEnt[mLfsr[IDX_W-1:0]] = en;
      TLB_SRCH: begin
        expLat = 1 + N;
        for (int i = 0; i < N; i++) begin
          if (!expHit && mEnt[i].e && (mEnt[i].g || mEnt[i].asid == asid)
              && pageMatch(mEnt[i], va)) begin
            expHit = 1'b1;
            expIdx = i;
            expLat = 2 + i;
          end
        end
      end
      TLB_INV: begin
        if (invOp > 5'd6) begin
          expBad = 1'b1;
        end else begin
          expLat = 2 + N;
          for (int i = 0; i < N; i++) begin
            if (invCond(mEnt[i], int'(invOp), asid, va)) mEnt[i].e = 1'b0;
          end
        end
      end
      default: ;
    endcase

    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_index  = idx;
    bus.req_entry  = en;
    bus.req_asid   = asid;
    bus.req_va     = va;
    bus.req_inv_op = invOp;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 3 * N) begin
      @(negedge clk);
      lat++;
    end

    checkOutput("resp_valid", bus.resp_valid, 1'b1);
    checkOutput($sformatf("latency_op%0d", op), lat, expLat);
    checkOutput("ready_low_in_resp", bus.req_ready, 1'b0);
    checkOutput("resp_inv_bad", bus.resp_inv_bad, expBad);
    if (op == TLB_SRCH) begin
      checkOutput("resp_hit", bus.resp_hit, expHit);
      if (expHit) checkOutput("resp_index", bus.resp_index, expIdx);
    end
    if (op == TLB_RD) checkOutput("resp_entry", bus.resp_entry, expEntry);
    checkArray("entrys");
    @(negedge clk);
    checkOutput("resp_pulse_end", bus.resp_valid, 1'b0);
  endtask

  initial begin
    tlb_entry_t en;
    tlb_entry_t blank;
    int         r;

    blank          = '0;
    bus.req_valid  = 1'b0;
    bus.req_op     = TLB_SRCH;
    bus.req_index  = '0;
    bus.req_entry  = '0;
    bus.req_asid   = '0;
    bus.req_va     = '0;
    bus.req_inv_op = '0;
    for (int i = 0; i < N; i++) mEnt[i] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", bus.req_ready, 1'b1);
    checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst_resp_hit", bus.resp_hit, 1'b0);
    checkOutput("rst_resp_inv_bad", bus.resp_inv_bad, 1'b0);
    checkOutput("rst_resp_index", bus.resp_index, 0);
    checkOutput("rst_resp_entry", bus.resp_entry, 0);
    checkArray("rst_entrys");
    rst_n = 1'b1;
    @(negedge clk);

    // WR index 3 then RD it back.
    $display("[TB] WR/RD");
    en      = '0;
    en.e    = 1'b1;
    en.vppn = 19'h12345;
    en.asid = 10'd5;
    en.ps   = 6'd12;
    en.p0   = tlb_entry_phy_t'(26'h1234567);
    en.p1   = tlb_entry_phy_t'(26'h2ABCDEF);
    applyStimulus(TLB_WR, 4'd3, en, '0, '0, '0);
    applyStimulus(TLB_RD, 4'd3, blank, '0, '0, '0);
    checkOutput("rd_matches_wr", bus.resp_entry, en);

    // Search: first of several matches wins; wrong ASID misses.
    $display("[TB] SRCH");
    applyStimulus(TLB_WR, 4'd2, en, '0, '0, '0);
    applyStimulus(TLB_WR, 4'd7, en, '0, '0, '0);
    applyStimulus(TLB_SRCH, '0, blank, 10'd5, 32'h2468_A000, '0);
    checkOutput("srch_first_index", bus.resp_index, 2);
    applyStimulus(TLB_SRCH, '0, blank, 10'd6, 32'h2468_A000, '0);

    // 4MB page: only vppn[18:9] takes part in the compare.
    $display("[TB] 4MB");
    en      = '0;
    en.e    = 1'b1;
    en.g    = 1'b1;
    en.asid = 10'd5;
    en.ps   = 6'd21;
    en.vppn = 19'h1FE00;
    applyStimulus(TLB_WR, 4'd9, en, '0, '0, '0);
    applyStimulus(TLB_SRCH, '0, blank, 10'd6, 32'h3FDF_F000, '0);
    checkOutput("srch_4mb_index", bus.resp_index, 9);

    // INVTLB op 4 over mixed global / non-global entries, then a bad op.
    $display("[TB] INVTLB");
    en      = '0;
    en.e    = 1'b1;
    en.g    = 1'b0;
    en.asid = 10'd6;
    en.vppn = 19'h00777;
    applyStimulus(TLB_WR, 4'd11, en, '0, '0, '0);
    applyStimulus(TLB_INV, '0, blank, 10'd5, '0, 5'd4);
    checkOutput("inv4_keeps_global", bus.entrys[9].e, 1'b1);
    checkOutput("inv4_clears_asid5", bus.entrys[2].e, 1'b0);
    applyStimulus(TLB_INV, '0, blank, 10'd5, '0, 5'd9);

    // Back-to-back FILLs following the LFSR sequence.
    $display("[TB] FILL");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(TLB_FILL, '0, randEntry(), '0, '0, '0);
    end

    // Randomized mix of all operations.
    $display("[TB] random");
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(9);
      case (r)
        0, 1:    applyStimulus(TLB_WR, 4'($urandom), randEntry(), '0, '0, '0);
        2:       applyStimulus(TLB_FILL, '0, randEntry(), '0, '0, '0);
        3:       applyStimulus(TLB_RD, 4'($urandom), blank, '0, '0, '0);
        4, 5, 6: applyStimulus(TLB_SRCH, '0, blank, asid_t'(5 + $urandom_range(2)),
                               randVa(), '0);
        default: applyStimulus(TLB_INV, '0, blank, asid_t'(5 + $urandom_range(2)),
                               randVa(), ($urandom_range(5) == 0) ?
                               5'(7 + $urandom_range(24)) : 5'($urandom_range(6)));
      endcase
    end

    // Reset in the middle of an INV walk.
    $display("[TB] reset mid-INV");
    for (int i = 0; i < 4; i++) begin
      en   = randEntry();
      en.e = 1'b1;
      applyStimulus(TLB_WR, 4'(i * 3), en, '0, '0, '0);
    end
    bus.req_valid  = 1'b1;
    bus.req_op     = TLB_INV;
    bus.req_inv_op = 5'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mEnt[i] = '0;
    checkOutput("midrst_resp_valid", bus.resp_valid, 1'b0);
    checkArray("midrst_entrys");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_after_release", bus.req_ready, 1'b1);
    checkOutput("midrst_no_resp", bus.resp_valid, 1'b0);

    en      = randEntry();
    en.e    = 1'b1;
    applyStimulus(TLB_WR, 4'd5, en, '0, '0, '0);
    applyStimulus(TLB_RD, 4'd5, blank, '0, '0, '0);
    applyStimulus(TLB_FILL, '0, randEntry(), '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
